// File: rtl/reg_viewer_pkg.sv
// Shared types and constants for the register hex viewer: sampling FSM states
// and the active-low seven-segment glyph set {g,f,e,d,c,b,a}.
package reg_viewer_pkg;

    typedef enum logic [1:0] {
        SELECT  = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } view_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry n is the glyph for nibble value n (index 15 listed first).
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] glyph(input logic [3:0] nibble);
        return SEG_GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_7seg
    import reg_viewer_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = glyph(nibble_i);
    end

endmodule

// File: rtl/key_debouncer.sv
// Synchronises an active-low push-button, debounces it and emits a single-cycle
// pulse on each accepted released->pressed transition.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // Flops reset to the released level so reset never looks like a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/reg_hex_viewer.sv
// Steps a register index (button or timer), samples the datapath readback for
// that index and shows the captured word on eight hex digits.
module reg_hex_viewer
    import reg_viewer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCAN_PERIOD     = 50000000,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_next_n,
    input  logic        auto_scan,
    input  logic        show_pc,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    input  logic [31:0] pc_in,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic [4:0]  ledr_sel,
    output logic        valid
);

    localparam int unsigned SCAN_W   = $clog2(SCAN_PERIOD + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    logic                auto_meta_q;
    logic                auto_q;
    logic                pcsel_meta_q;
    logic                pcsel_q;
    logic                press;
    logic [SCAN_W-1:0]   scan_q;
    logic                advance;

    view_state_e         state_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [4:0]          index_q;
    logic [4:0]          reg_sel_q;
    logic [31:0]         latch_q;
    logic                valid_q;
    logic [6:0]          seg [8];

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i   (clock),
        .rst_i   (reset),
        .key_n_i (key_next_n),
        .press_o (press)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            auto_meta_q  <= 1'b0;
            auto_q       <= 1'b0;
            pcsel_meta_q <= 1'b0;
            pcsel_q      <= 1'b0;
        end else begin
            auto_meta_q  <= auto_scan;
            auto_q       <= auto_meta_q;
            pcsel_meta_q <= show_pc;
            pcsel_q      <= pcsel_meta_q;
        end
    end

    // Held at zero in manual mode so enabling auto-scan waits a full period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
        end else if (!auto_q || scan_q == SCAN_W'(SCAN_PERIOD - 1)) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
        end
    end

    always_comb begin
        advance = auto_q ? (scan_q == SCAN_W'(SCAN_PERIOD - 1)) : press;
    end

    // An advance overrides whatever the sampler was doing and restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= SELECT;
            settle_q  <= '0;
            index_q   <= '0;
            reg_sel_q <= '0;
            latch_q   <= '0;
            valid_q   <= 1'b0;
        end else if (advance) begin
            index_q  <= index_q + 5'd1;
            valid_q  <= 1'b0;
            settle_q <= '0;
            state_q  <= SELECT;
        end else begin
            case (state_q)
                SELECT: begin
                    reg_sel_q <= index_q;
                    settle_q  <= '0;
                    state_q   <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= CAPTURE;
                    end else begin
                        settle_q <= settle_q + SETTLE_W'(1);
                    end
                end
                CAPTURE: begin
                    latch_q <= pcsel_q ? pc_in : reg_data;
                    valid_q <= 1'b1;
                    state_q <= SELECT;
                end
                default: begin
                    state_q <= SELECT;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_digit
        hex_to_7seg u_seg (
            .nibble_i (latch_q[g*4 +: 4]),
            .seg_o    (seg[g])
        );
    end

    assign hex0     = valid_q ? seg[0] : SEG_BLANK;
    assign hex1     = valid_q ? seg[1] : SEG_BLANK;
    assign hex2     = valid_q ? seg[2] : SEG_BLANK;
    assign hex3     = valid_q ? seg[3] : SEG_BLANK;
    assign hex4     = valid_q ? seg[4] : SEG_BLANK;
    assign hex5     = valid_q ? seg[5] : SEG_BLANK;
    assign hex6     = valid_q ? seg[6] : SEG_BLANK;
    assign hex7     = valid_q ? seg[7] : SEG_BLANK;
    assign reg_sel  = reg_sel_q;
    assign ledr_sel = index_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_reg_hex_viewer.sv
// Self-checking bench for reg_hex_viewer with a small-parameter configuration
// and a datapath modelled as an array lookup on reg_sel.
module tb_reg_hex_viewer;

    localparam int unsigned DEB    = 4;
    localparam int unsigned SCAN   = 16;
    localparam int unsigned SETTLE = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_next_n;
    logic        auto_scan;
    logic        show_pc;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [31:0] pc_in;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [4:0]  ledr_sel;
    logic        valid;

    logic [31:0] regs [32];
    logic [55:0] hex_all;
    logic [55:0] blank_all = {8{7'b1111111}};
    logic [6:0]  glyph_tb [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [4:0]  exp_idx;

    assign reg_data = regs[reg_sel];
    assign hex_all  = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    always #5 clock = ~clock;

    reg_hex_viewer #(
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_PERIOD    (SCAN),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_next_n (key_next_n),
        .auto_scan  (auto_scan),
        .show_pc    (show_pc),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .pc_in      (pc_in),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .hex6       (hex6),
        .hex7       (hex7),
        .ledr_sel   (ledr_sel),
        .valid      (valid)
    );

    function automatic logic [55:0] word_to_hex(input logic [31:0] w);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i*7 +: 7] = glyph_tb[w[i*4 +: 4]];
        end
        return r;
    endfunction

    task automatic wait_change(output int cycles, output logic [4:0] nv);
        logic [4:0] start;
        start  = ledr_sel;
        cycles = 0;
        while (ledr_sel === start && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
        nv = ledr_sel;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        key_next_n = 1'b1;
        auto_scan  = 1'b0;
        show_pc    = 1'b0;
        pc_in      = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0;
        regs[1] = 32'h0000_0007;
        regs[31] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({valid, hex_all} !== {1'b0, blank_all}) begin
            tests_failed++;
            $display("FAIL reset_blank: got %h expected %h", {valid, hex_all}, {1'b0, blank_all});
        end
        reset   = 1'b0;
        exp_idx = 5'd0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({valid, hex_all} !== {1'b0, blank_all}) begin
            tests_failed++;
            $display("FAIL post_reset_blank: got %h expected %h", {valid, hex_all}, {1'b0, blank_all});
        end
        @(negedge clock);
        tests_run++;
        if ({valid, reg_sel, hex_all} !== {1'b1, 5'd0, word_to_hex(regs[0])}) begin
            tests_failed++;
            $display("FAIL first_capture: got %h expected %h", {valid, reg_sel, hex_all},
                     {1'b1, 5'd0, word_to_hex(regs[0])});
        end
    endtask

    task automatic test_manual();
        int         adv = 0;
        int         first = -1;
        logic [4:0] prev;
        logic       vdrop = 1'b1, v3 = 1'b1, v4 = 1'b0;
        logic [55:0] h4 = '0;
        prev = ledr_sel;
        key_next_n = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 6) key_next_n = 1'b1;
            @(negedge clock);
            if (ledr_sel !== prev) begin
                adv++;
                prev = ledr_sel;
                if (first < 0) begin
                    first = c;
                    vdrop = valid;
                end
            end
            if (first >= 0 && c == first + 3) v3 = valid;
            if (first >= 0 && c == first + 4) begin
                v4 = valid;
                h4 = hex_all;
            end
        end
        exp_idx = exp_idx + 5'd1;
        tests_run++;
        if (adv != 1 || ledr_sel !== exp_idx) begin
            tests_failed++;
            $display("FAIL manual_advance: got %0d advances idx %0d expected 1 advance idx %0d",
                     adv, ledr_sel, exp_idx);
        end
        tests_run++;
        if ({vdrop, v3} !== 2'b00) begin
            tests_failed++;
            $display("FAIL manual_valid_drop: got %b expected 00", {vdrop, v3});
        end
        tests_run++;
        if ({v4, h4} !== {1'b1, word_to_hex(regs[exp_idx])}) begin
            tests_failed++;
            $display("FAIL manual_latency: got %h expected %h", {v4, h4}, {1'b1, word_to_hex(regs[exp_idx])});
        end
    endtask

    task automatic test_bouncy();
        int         adv = 0;
        logic [4:0] prev;
        prev = ledr_sel;
        for (int c = 0; c < 50; c++) begin
            if (c < 10)       key_next_n = ((c / 2) % 2) == 1;
            else if (c < 30)  key_next_n = 1'b0;
            else              key_next_n = 1'b1;
            @(negedge clock);
            if (ledr_sel !== prev) begin
                adv++;
                prev = ledr_sel;
            end
        end
        exp_idx = exp_idx + 5'd1;
        tests_run++;
        if (adv != 1 || ledr_sel !== exp_idx) begin
            tests_failed++;
            $display("FAIL bouncy_advance: got %0d advances idx %0d expected 1 advance idx %0d",
                     adv, ledr_sel, exp_idx);
        end
        tests_run++;
        if ({valid, hex_all} !== {1'b1, word_to_hex(regs[exp_idx])}) begin
            tests_failed++;
            $display("FAIL bouncy_display: got %h expected %h", {valid, hex_all}, {1'b1, word_to_hex(regs[exp_idx])});
        end
    endtask

    task automatic test_auto();
        logic       moved = 1'b0;
        logic       bad = 1'b0;
        int         cyc;
        int         iter = 0;
        logic [4:0] nv;
        logic [4:0] start;
        start = ledr_sel;
        auto_scan = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) key_next_n = 1'b0;
            if (c == 9) key_next_n = 1'b1;
            @(negedge clock);
            if (ledr_sel !== start) moved = 1'b1;
        end
        tests_run++;
        if (moved !== 1'b0) begin
            tests_failed++;
            $display("FAIL auto_press_ignored: got moved=%b expected 0", moved);
        end
        wait_change(cyc, nv);
        exp_idx = exp_idx + 5'd1;
        tests_run++;
        if (nv !== exp_idx) begin
            tests_failed++;
            $display("FAIL auto_first: got idx %0d after %0d cycles expected %0d", nv, cyc, exp_idx);
        end
        while (exp_idx != 5'd30 && iter < 40) begin
            wait_change(cyc, nv);
            if (cyc != SCAN || nv !== exp_idx + 5'd1) bad = 1'b1;
            exp_idx = exp_idx + 5'd1;
            iter++;
        end
        tests_run++;
        if (bad !== 1'b0 || ledr_sel !== 5'd30) begin
            tests_failed++;
            $display("FAIL auto_period: got bad=%b idx %0d expected bad=0 idx 30", bad, ledr_sel);
        end
        wait_change(cyc, nv);
        exp_idx = 5'd31;
        tests_run++;
        if (cyc != SCAN || nv !== exp_idx || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL auto_to_31: got %0d cycles idx %0d valid %b expected %0d cycles idx 31 valid 0",
                     cyc, nv, valid, SCAN);
        end
        repeat (SETTLE + 2) @(negedge clock);
        tests_run++;
        if ({valid, hex_all} !== {1'b1, word_to_hex(32'hDEAD_BEEF)}) begin
            tests_failed++;
            $display("FAIL auto_deadbeef: got %h expected %h", {valid, hex_all}, {1'b1, word_to_hex(32'hDEAD_BEEF)});
        end
        tests_run++;
        if ({hex7, hex0} !== {7'b0100001, 7'b0001110}) begin
            tests_failed++;
            $display("FAIL auto_deadbeef_ends: got %b %b expected 0100001 0001110", hex7, hex0);
        end
        wait_change(cyc, nv);
        auto_scan = 1'b0;
        exp_idx   = 5'd0;
        tests_run++;
        if (cyc + SETTLE + 2 != SCAN || nv !== exp_idx) begin
            tests_failed++;
            $display("FAIL auto_wrap: got %0d cycles idx %0d expected %0d cycles idx 0",
                     cyc + SETTLE + 2, nv, SCAN);
        end
    endtask

    task automatic test_show_pc();
        logic vbad = 1'b0;
        repeat (6) @(negedge clock);
        tests_run++;
        if ({valid, hex_all} !== {1'b1, word_to_hex(regs[exp_idx])}) begin
            tests_failed++;
            $display("FAIL pc_before: got %h expected %h", {valid, hex_all}, {1'b1, word_to_hex(regs[exp_idx])});
        end
        show_pc = 1'b1;
        pc_in   = 32'h0000_0040;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (valid !== 1'b1) vbad = 1'b1;
        end
        tests_run++;
        if (vbad !== 1'b0) begin
            tests_failed++;
            $display("FAIL pc_valid_held: got drop=%b expected 0", vbad);
        end
        tests_run++;
        if ({hex1, hex_all} !== {7'b0011001, word_to_hex(32'h0000_0040)}) begin
            tests_failed++;
            $display("FAIL pc_display: got %h expected %h", {hex1, hex_all}, {7'b0011001, word_to_hex(32'h40)});
        end
        pc_in = $urandom;
        repeat (6) @(negedge clock);
        tests_run++;
        if ({valid, hex_all} !== {1'b1, word_to_hex(pc_in)}) begin
            tests_failed++;
            $display("FAIL pc_tracks: got %h expected %h", {valid, hex_all}, {1'b1, word_to_hex(pc_in)});
        end
        show_pc = 1'b0;
        repeat (8) @(negedge clock);
        tests_run++;
        if ({valid, hex_all} !== {1'b1, word_to_hex(regs[exp_idx])}) begin
            tests_failed++;
            $display("FAIL pc_back_to_reg: got %h expected %h", {valid, hex_all}, {1'b1, word_to_hex(regs[exp_idx])});
        end
    endtask

    task automatic test_reset_mid();
        int         cyc;
        logic [4:0] nv;
        for (int k = 0; k < 4; k++) begin
            key_next_n = 1'b0;
            repeat (6) @(negedge clock);
            key_next_n = 1'b1;
            repeat (12) @(negedge clock);
            exp_idx = exp_idx + 5'd1;
        end
        tests_run++;
        if (ledr_sel !== exp_idx) begin
            tests_failed++;
            $display("FAIL presses_to_4: got %0d expected %0d", ledr_sel, exp_idx);
        end
        key_next_n = 1'b0;
        wait_change(cyc, nv);
        exp_idx = exp_idx + 5'd1;
        @(negedge clock);
        tests_run++;
        if ({nv, reg_sel, valid} !== {exp_idx, exp_idx, 1'b0}) begin
            tests_failed++;
            $display("FAIL reach_5: got %h expected %h", {nv, reg_sel, valid}, {exp_idx, exp_idx, 1'b0});
        end
        #2;
        reset      = 1'b1;
        key_next_n = 1'b1;
        #1;
        tests_run++;
        if ({valid, ledr_sel, reg_sel, hex_all} !== {1'b0, 5'd0, 5'd0, blank_all}) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected %h", {valid, ledr_sel, reg_sel, hex_all},
                     {1'b0, 5'd0, 5'd0, blank_all});
        end
        repeat (2) @(negedge clock);
        reset   = 1'b0;
        exp_idx = 5'd0;
        repeat (SETTLE + 2) @(negedge clock);
        tests_run++;
        if ({valid, ledr_sel, hex_all} !== {1'b1, 5'd0, word_to_hex(regs[0])}) begin
            tests_failed++;
            $display("FAIL resume_after_reset: got %h expected %h", {valid, ledr_sel, hex_all},
                     {1'b1, 5'd0, word_to_hex(regs[0])});
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bouncy();
        test_auto();
        test_show_pc();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
